pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipelined CPU (IF/ID/EXE/MEM/WB).
- Keeps shadow copies of the EXE and MEM destination-register info and advances them in lockstep with the datapath.
- From these it generates the forwarding selects, the load-use stall, the branch flush and the multi-cycle-op hold.
- Replaces the ad-hoc combinational hazard logic in the CPU top level. Its outputs drive the datapath's pipeline-register write enables and the forwarding muxes.

Parameters:
- MC_CYCLES, 4, total EXE occupancy of a multi-cycle op (mult/div). Legal range 2..15.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  reset. One clock; reset is asynchronous and active-low.
- id_rs  in  5  source register rs of the instruction in ID.
- id_rt  in  5  source register rt of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_wreg  in  1  ID instruction writes the register file.
- id_rn  in  5  destination register of the ID instruction.
- id_m2reg  in  1  ID instruction is a load (result comes from memory).
- id_mc  in  1  ID instruction is a multi-cycle EXE op.
- id_branch_taken  in  1  ID resolved a taken branch or jump (pcsource != 0).
- stall  out  1  freeze PC and IF/ID; insert bubble into ID/EXE.
- pc_wen  out  1  PC write enable.
- ifid_wen  out  1  IF/ID write enable.
- ifid_flush  out  1  load NOP into IF/ID on the next edge.
- exe_hold  out  1  freeze ID/EXE and the EXE unit; insert bubble into EXE/MEM.
- FwdA  out  2  rs operand select: 00 regfile, 01 exe_Alu_Result, 10 mem_Alu_Result, 11 mem_mo.
- FwdB  out  2  rt operand select, same encoding as FwdA.
- mc_busy  out  1  FSM is in BUSY.
- stall_cnt  out  CNT_W  saturating count of cycles with stall or exe_hold asserted.

Behaviour:
- Reset (async, Resetn=0):
  - Shadow slots ex_* and mem_* are cleared (wreg=0, rn=0, m2reg=0).
  - FSM goes to IDLE; the MC counter and stall_cnt go to 0.
  - Combinational outputs at reset: stall=0, exe_hold=0, ifid_flush=0, FwdA=FwdB=00, pc_wen=ifid_wen=1, mc_busy=0.
- Shadow advance on each rising edge:
  - exe_hold=1: EXE slot holds; MEM slot loads a bubble.
  - else stall=1: MEM gets EXE; EXE loads a bubble.
  - else: MEM gets EXE; EXE loads the ID fields (id_wreg, id_rn, id_m2reg).
- Forwarding (combinational, per operand; rs shown, rt is identical):
  - If ex_wreg & ex_rn!=0 & ex_rn==id_rs & !ex_m2reg, then 01.
  - Else if mem_wreg & mem_rn!=0 & mem_rn==id_rs, then 11 when mem_m2reg, otherwise 10.
  - Else 00.
  - EXE has priority over MEM. A match on register 0 never forwards.
  - During BUSY the ex_* slot is treated as not forwardable.
- Load-use hazard:
  - lu = ex_wreg & ex_m2reg & ex_rn!=0 & ((id_use_rs & id_rs==ex_rn) | (id_use_rt & id_rt==ex_rn)).
  - Produces a 1-cycle stall; the next cycle forwards 11 from MEM.
- Multi-cycle FSM:
  - IDLE: if id_mc, not stalled and not flushed, the op enters EXE; load cnt=MC_CYCLES-1; go to BUSY.
  - BUSY: exe_hold=1 and cnt decrements each cycle. When cnt==1 on an edge, go to IDLE, so exe_hold is asserted for exactly MC_CYCLES-1 cycles.
  - A dependent instruction in ID of an MC result waits until BUSY ends, then receives 01.
- Priority: reset > exe_hold > lu > branch.
  - stall = exe_hold | lu.
  - pc_wen = ifid_wen = !stall.
  - ifid_flush = id_branch_taken & !stall. A branch seen during a stall is ignored until its operands are valid.
- stall_cnt: increments when stall=1 and saturates at all-ones. It is cleared only by reset.
- Reset mid-BUSY: the FSM returns to IDLE immediately and the held op is discarded.

Test Plan:
- Reset with Resetn=0 for 50 ns, then release → all outputs at reset values and the first 3 cycles show stall=0 with forwarding selects 00.
- ALU back-to-back: add r3,r1,r2 then sub r4,r3,r1 → FwdA=01 on sub in ID. An intervening NOP → FwdA=10.
- Load-use: lw r5,0(r0) then add r6,r5,r5 → exactly 1 cycle with stall=1 and pc_wen=0, then FwdA=FwdB=11; stall_cnt=1.
- Taken branch at ID with no hazard → ifid_flush=1 for 1 cycle. Same branch whose rs equals a load destination in EXE → stall first, then flush on the following cycle.
- With MC_CYCLES=4, a div followed by a dependent add → mc_busy=1 and exe_hold=1 for 3 cycles, MEM sees 3 bubbles, then add gets FwdA=01; stall_cnt=3.
- Write to r0 by the EXE instruction with the ID instruction reading r0 → FwdA=00 and no stall. Resetn pulsed low during BUSY → mc_busy=0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipe: shadows EXE/MEM destination info,
// derives forwarding selects, load-use stall, branch flush and multi-cycle EXE hold.
module pipe_hazard_ctrl #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic [4:0]       id_rn,
  input  logic             id_m2reg,
  input  logic             id_mc,
  input  logic             id_branch_taken,
  output logic             stall,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             exe_hold,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mc_state_t;

  localparam logic [3:0]       MC_CNT_INIT = 4'(MC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  mc_state_t  state_q, state_d;
  logic [3:0] mc_cnt_q;

  logic       ex_wreg_q, ex_m2reg_q, mem_wreg_q, mem_m2reg_q;
  logic [4:0] ex_rn_q, mem_rn_q;

  logic       lu, mc_start, ex_fwd_ok, mem_fwd_ok;
  logic [1:0] mem_sel;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mc_start) state_d = BUSY;
      BUSY:    if (mc_cnt_q == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mc_busy  = (state_q == BUSY);
    exe_hold = (state_q == BUSY);
  end

  // Counts remaining hold cycles; the op stays in EXE until it reaches 1.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                          mc_cnt_q <= 4'd0;
    else if (state_q == IDLE && mc_start) mc_cnt_q <= MC_CNT_INIT;
    else if (state_q == BUSY)             mc_cnt_q <= mc_cnt_q - 4'd1;
  end

  assign lu = ex_wreg_q & ex_m2reg_q & (ex_rn_q != 5'd0) &
              ((id_use_rs & (id_rs == ex_rn_q)) | (id_use_rt & (id_rt == ex_rn_q)));

  assign stall      = exe_hold | lu;
  assign pc_wen     = ~stall;
  assign ifid_wen   = ~stall;
  assign ifid_flush = id_branch_taken & ~stall & Resetn;
  assign mc_start   = id_mc & ~stall & ~ifid_flush;

  // A held multi-cycle result is not ready yet, so EXE never forwards while BUSY.
  assign ex_fwd_ok  = ex_wreg_q & ~ex_m2reg_q & (ex_rn_q != 5'd0) & ~mc_busy;
  assign mem_fwd_ok = mem_wreg_q & (mem_rn_q != 5'd0);
  assign mem_sel    = mem_m2reg_q ? 2'b11 : 2'b10;

  always_comb begin
    FwdA = 2'b00;
    if (ex_fwd_ok && ex_rn_q == id_rs)        FwdA = 2'b01;
    else if (mem_fwd_ok && mem_rn_q == id_rs) FwdA = mem_sel;
  end

  always_comb begin
    FwdB = 2'b00;
    if (ex_fwd_ok && ex_rn_q == id_rt)        FwdB = 2'b01;
    else if (mem_fwd_ok && mem_rn_q == id_rt) FwdB = mem_sel;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ex_wreg_q   <= 1'b0;
      ex_rn_q     <= 5'd0;
      ex_m2reg_q  <= 1'b0;
      mem_wreg_q  <= 1'b0;
      mem_rn_q    <= 5'd0;
      mem_m2reg_q <= 1'b0;
    end else if (exe_hold) begin
      mem_wreg_q  <= 1'b0;
      mem_rn_q    <= 5'd0;
      mem_m2reg_q <= 1'b0;
    end else begin
      mem_wreg_q  <= ex_wreg_q;
      mem_rn_q    <= ex_rn_q;
      mem_m2reg_q <= ex_m2reg_q;
      if (stall) begin
        ex_wreg_q  <= 1'b0;
        ex_rn_q    <= 5'd0;
        ex_m2reg_q <= 1'b0;
      end else begin
        ex_wreg_q  <= id_wreg;
        ex_rn_q    <= id_rn;
        ex_m2reg_q <= id_m2reg;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                        stall_cnt <= '0;
    else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule
